// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide sequencing controller:
//   - MdOp encodings and their width
//   - default busy durations for multiply and divide
//   - FSM state encoding
//   - small helpers that classify an operation
// ---------------------------------------------------------------------------
package md_pkg;

   localparam int MD_OP_W = 3;

   typedef enum logic [MD_OP_W-1:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   localparam int unsigned MUL_CYCLES_DEF = 32'd5;
   localparam int unsigned DIV_CYCLES_DEF = 32'd10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // True for the two divide operations.
   function automatic logic is_div_op(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for any operation that occupies the unit for several cycles.
   function automatic logic is_arith_op(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
   endfunction

endpackage : md_pkg

// File: rtl/md_compute.sv
// ---------------------------------------------------------------------------
// md_compute
// Purely combinational result path for the multiply/divide unit. Works on
// the operands latched by the controller, so the sequencing logic never has
// to look at arithmetic details.
// Ports:
//   op          latched operation
//   a, b        latched rs / rt operands
//   hi_res      value destined for HI (product high word / remainder)
//   lo_res      value destined for LO (product low word / quotient)
//   div_by_zero high when op is DIV/DIVU and b is zero
// ---------------------------------------------------------------------------
module md_compute
   import md_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi_res,
   output logic [31:0] lo_res,
   output logic        div_by_zero
);

   logic        b_zero_s;
   logic [31:0] b_safe_s;
   logic [63:0] prod_u_s;
   logic [63:0] prod_s_s;
   logic [31:0] quo_u_s;
   logic [31:0] rem_u_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [31:0] quo_mag_s;
   logic [31:0] rem_mag_s;
   logic [31:0] quo_s_s;
   logic [31:0] rem_s_s;

   assign b_zero_s    = (b == 32'd0);
   assign div_by_zero = b_zero_s && is_div_op(op);
   // A zero divisor never commits; substituting 1 keeps the divider defined.
   assign b_safe_s    = b_zero_s ? 32'd1 : b;

   assign prod_u_s = {32'd0, a} * {32'd0, b};
   assign prod_s_s = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));

   assign quo_u_s = a / b_safe_s;
   assign rem_u_s = a % b_safe_s;

   // Signed divide on magnitudes: 0x80000000 negates to itself, which is the
   // correct unsigned magnitude, so the overflow case falls out naturally.
   assign a_mag_s   = a[31] ? (32'd0 - a) : a;
   assign b_mag_s   = b_safe_s[31] ? (32'd0 - b_safe_s) : b_safe_s;
   assign quo_mag_s = a_mag_s / b_mag_s;
   assign rem_mag_s = a_mag_s % b_mag_s;

   // Quotient truncates toward zero; remainder follows the dividend sign.
   always_comb begin
      if (a[31] ^ b_safe_s[31]) begin
         quo_s_s = 32'd0 - quo_mag_s;
      end else begin
         quo_s_s = quo_mag_s;
      end
      if (a[31]) begin
         rem_s_s = 32'd0 - rem_mag_s;
      end else begin
         rem_s_s = rem_mag_s;
      end
   end

   // Select the HI/LO result for the latched operation.
   always_comb begin
      hi_res = 32'd0;
      lo_res = 32'd0;
      case (op)
         MD_MULT: begin
            hi_res = prod_s_s[63:32];
            lo_res = prod_s_s[31:0];
         end
         MD_MULTU: begin
            hi_res = prod_u_s[63:32];
            lo_res = prod_u_s[31:0];
         end
         MD_DIV: begin
            hi_res = rem_s_s;
            lo_res = quo_s_s;
         end
         MD_DIVU: begin
            hi_res = rem_u_s;
            lo_res = quo_u_s;
         end
         default: begin
            hi_res = 32'd0;
            lo_res = 32'd0;
         end
      endcase
   end

endmodule : md_compute

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// Sequencing controller for the multiply/divide resource of the pipelined
// MIPS core. Owns HI/LO, emulates a fixed multi-cycle latency and reports
// Busy so the hazard unit can stall HI/LO readers and new md operations.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset, dominates everything
//   Start   E-stage md instruction valid
//   MdOp    operation code (see md_pkg), sampled with Start
//   A, B    rs / rt operands
//   Cancel  abort the in-flight op and drop a same-cycle Start
//   Busy    registered, high while an op is in progress
//   HI, LO  architectural HI/LO registers
// ---------------------------------------------------------------------------
module mdu_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Start,
   input  logic [MD_OP_W-1:0] MdOp,
   input  logic [31:0]        A,
   input  logic [31:0]        B,
   input  logic               Cancel,
   output logic               Busy,
   output logic [31:0]        HI,
   output logic [31:0]        LO
);

   md_state_e   state_q, state_d;
   logic [31:0] cnt_q,   cnt_d;
   logic        busy_q,  busy_d;
   logic [31:0] hi_q,    hi_d;
   logic [31:0] lo_q,    lo_d;
   md_op_e      op_q,    op_d;
   logic [31:0] a_q,     a_d;
   logic [31:0] b_q,     b_d;

   md_op_e      op_in_s;
   logic [31:0] hi_res_s;
   logic [31:0] lo_res_s;
   logic        div_by_zero_s;

   assign op_in_s = md_op_e'(MdOp);

   md_compute u_compute (
      .op          (op_q),
      .a           (a_q),
      .b           (b_q),
      .hi_res      (hi_res_s),
      .lo_res      (lo_res_s),
      .div_by_zero (div_by_zero_s)
   );

   // Next-state logic: accept ops in IDLE, count down and commit in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (Start && !Cancel) begin
               case (op_in_s)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     op_d    = op_in_s;
                     a_d     = A;
                     b_d     = B;
                     cnt_d   = is_div_op(op_in_s) ? DIV_CYCLES : MUL_CYCLES;
                     state_d = ST_RUN;
                     busy_d  = 1'b1;
                  end
                  MD_MTHI: begin
                     hi_d = A;
                  end
                  MD_MTLO: begin
                     lo_d = A;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Start is ignored here; only Cancel or the countdown matter.
            if (Cancel) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = 32'd0;
            end else if (cnt_q <= 32'd1) begin
               if (!div_by_zero_s) begin
                  hi_d = hi_res_s;
                  lo_d = lo_res_s;
               end else begin
                  hi_d = hi_q;
                  lo_d = lo_q;
               end
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = 32'd0;
         end
      endcase
   end

   // State, counter, operand latches and HI/LO with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 32'd0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         op_q    <= MD_NONE;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule : mdu_ctrl
